// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: requester ids and the muxed request payload.
package data_mem_arbiter_pkg;

    localparam int REQ_LSU   = 0;
    localparam int REQ_FETCH = 1;

    // The rs id is carried next to this payload because its width is a module parameter.
    typedef struct packed {
        logic [4:0]  reg_addr;
        logic [31:0] address;
        logic [3:0]  write_en;
        logic [31:0] write_data;
        logic [3:0]  read_en;
    } mem_req_t;

endpackage

// File: rtl/data_mem_arbiter_tag_fifo.sv
// In-order FIFO of 1-bit requester ids, one entry per request still awaiting its memory response.
module mem_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] tag_q, tag_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = tag_q[rd_ptr_q];

    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        if (do_push) begin
            tag_d[wr_ptr_q] = push_id;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the load/store unit and instruction fetch,
// with the grant held through memory stalls and responses routed back by an in-order tag FIFO.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int RS_ID_WIDTH     = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [1:0][RS_ID_WIDTH-1:0]  req_rs_id,
    input  logic [1:0][4:0]              req_reg_addr,
    input  logic [1:0][31:0]             req_address,
    input  logic [1:0][3:0]              req_write_en,
    input  logic [1:0][31:0]             req_write_data,
    input  logic [1:0][3:0]              req_read_en,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [RS_ID_WIDTH-1:0]       mem_rs_id,
    output logic [4:0]                   mem_reg_addr,
    output logic [31:0]                  mem_address,
    output logic [3:0]                   mem_write_en,
    output logic [31:0]                  mem_write_data,
    output logic [3:0]                   mem_read_en,
    input  logic                         mem_resp_valid,
    output logic                         mem_resp_ready,
    input  logic [RS_ID_WIDTH-1:0]       mem_resp_rs_id,
    input  logic [4:0]                   mem_resp_reg_addr,
    input  logic [31:0]                  mem_read_data,
    output logic [1:0]                   resp_valid,
    input  logic [1:0]                   resp_ready,
    output logic [RS_ID_WIDTH-1:0]       resp_rs_id,
    output logic [4:0]                   resp_reg_addr,
    output logic [31:0]                  resp_data
);

    logic     grant;
    logic     accept, stall, pop;
    logic     fifo_full, fifo_empty, fifo_head;
    logic     last_grant_q, last_grant_d;
    logic     lock_q, lock_d;
    logic     locked_id_q, locked_id_d;
    mem_req_t sel;

    // A stalled grant stays locked so the other requester cannot change the fields mid-request.
    always_comb begin
        grant = ~last_grant_q;
        if (lock_q) begin
            grant = locked_id_q;
        end else if (req_valid == 2'b01) begin
            grant = 1'(REQ_LSU);
        end else if (req_valid == 2'b10) begin
            grant = 1'(REQ_FETCH);
        end
    end

    assign mem_req_valid = rst & (|req_valid) & ~fifo_full;
    assign accept        = mem_req_valid & mem_req_ready;
    assign stall         = mem_req_valid & ~mem_req_ready;

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = accept;
    end

    always_comb begin
        sel.reg_addr   = req_reg_addr[grant];
        sel.address    = req_address[grant];
        sel.write_en   = req_write_en[grant];
        sel.write_data = req_write_data[grant];
        sel.read_en    = req_read_en[grant];
    end

    assign mem_rs_id      = req_rs_id[grant];
    assign mem_reg_addr   = sel.reg_addr;
    assign mem_address    = sel.address;
    assign mem_write_en   = sel.write_en;
    assign mem_write_data = sel.write_data;
    assign mem_read_en    = sel.read_en;

    always_comb begin
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        locked_id_d  = locked_id_q;
        if (accept) begin
            last_grant_d = grant;
            lock_d       = 1'b0;
        end else if (stall) begin
            lock_d      = 1'b1;
            locked_id_d = grant;
        end
    end

    // last_grant resets to FETCH so the LSU wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= 1'(REQ_FETCH);
            lock_q       <= 1'b0;
            locked_id_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            locked_id_q  <= locked_id_d;
        end
    end

    always_comb begin
        resp_valid            = '0;
        resp_valid[fifo_head] = rst & mem_resp_valid & ~fifo_empty;
    end

    assign mem_resp_ready = rst & resp_ready[fifo_head] & ~fifo_empty;
    assign pop            = mem_resp_valid & mem_resp_ready;
    assign resp_rs_id     = mem_resp_rs_id;
    assign resp_reg_addr  = mem_resp_reg_addr;
    assign resp_data      = mem_read_data;

    mem_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (grant),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed scenarios followed by randomized traffic.
module tb_data_mem_arbiter;

    localparam int MAXO = 4;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rg;
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [3:0]  re;
    } tx_t;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rg;
        logic [31:0] d;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [1:0][4:0] req_rs_id = '0;
    logic [1:0][4:0] req_reg_addr = '0;
    logic [1:0][31:0] req_address = '0;
    logic [1:0][3:0] req_write_en = '0;
    logic [1:0][31:0] req_write_data = '0;
    logic [1:0][3:0] req_read_en = '0;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b0;
    logic [4:0]      mem_rs_id;
    logic [4:0]      mem_reg_addr;
    logic [31:0]     mem_address;
    logic [3:0]      mem_write_en;
    logic [31:0]     mem_write_data;
    logic [3:0]      mem_read_en;
    logic            mem_resp_valid = 1'b0;
    logic            mem_resp_ready;
    logic [4:0]      mem_resp_rs_id = '0;
    logic [4:0]      mem_resp_reg_addr = '0;
    logic [31:0]     mem_read_data = '0;
    logic [1:0]      resp_valid;
    logic [1:0]      resp_ready = '0;
    logic [4:0]      resp_rs_id;
    logic [4:0]      resp_reg_addr;
    logic [31:0]     resp_data;

    int n_checks = 0;
    int n_errors = 0;

    tx_t  req_q[2][$];
    rsp_t exp_q[2][$];
    rsp_t mem_pend[$];
    logic m_ids[$];
    logic m_last = 1'b1;
    logic m_lock = 1'b0;
    logic m_lock_id = 1'b0;
    logic [1:0] acc_last = '0;

    logic [1:0] req_en = '0;
    logic       req_rnd = 1'b0;
    logic       mrdy = 1'b0;
    logic       mrdy_rnd = 1'b0;
    logic       resp_on = 1'b0;
    logic       resp_rnd = 1'b0;
    logic [1:0] rr = '0;
    logic       rr_rnd = 1'b0;

    data_mem_arbiter #(
        .RS_ID_WIDTH     (5),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_rs_id         (req_rs_id),
        .req_reg_addr      (req_reg_addr),
        .req_address       (req_address),
        .req_write_en      (req_write_en),
        .req_write_data    (req_write_data),
        .req_read_en       (req_read_en),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_rs_id         (mem_rs_id),
        .mem_reg_addr      (mem_reg_addr),
        .mem_address       (mem_address),
        .mem_write_en      (mem_write_en),
        .mem_write_data    (mem_write_data),
        .mem_read_en       (mem_read_en),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_ready    (mem_resp_ready),
        .mem_resp_rs_id    (mem_resp_rs_id),
        .mem_resp_reg_addr (mem_resp_reg_addr),
        .mem_read_data     (mem_read_data),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rs_id        (resp_rs_id),
        .resp_reg_addr     (resp_reg_addr),
        .resp_data         (resp_data)
    );

    always #5 clk = ~clk;

    // Contents of the bench's memory: a fixed function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a ^ 32'h5A5A_C3C3) + {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: arbitration and routing rules applied to the live inputs, plus the response scoreboard.
    always @(negedge clk) begin : monitor
        logic g, h, ev;
        logic [1:0] exp_rdy;
        rsp_t e;
        if (!rst) begin
            chk("rst_mem_req_valid", mem_req_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_mem_resp_ready", mem_resp_ready, 0);
            m_ids.delete();
            m_last = 1'b1;
            m_lock = 1'b0;
        end else begin
            ev = (|req_valid) && (m_ids.size() < MAXO);
            chk("mem_req_valid", mem_req_valid, ev);
            if (m_lock) g = m_lock_id;
            else if (req_valid == 2'b01) g = 1'b0;
            else if (req_valid == 2'b10) g = 1'b1;
            else g = !m_last;
            exp_rdy = 2'b00;
            if (ev) begin
                chk("mem_address", mem_address, req_address[g]);
                chk("mem_rs_id", mem_rs_id, req_rs_id[g]);
                chk("mem_write_data", mem_write_data, req_write_data[g]);
                if (mem_req_ready) exp_rdy = 2'b01 << g;
            end
            chk("req_ready", req_ready, exp_rdy);
            if (m_ids.size() > 0) begin
                h = m_ids[0];
                chk("resp_valid", resp_valid, mem_resp_valid ? (2'b01 << h) : 2'b00);
                chk("mem_resp_ready", mem_resp_ready, resp_ready[h]);
                if (mem_resp_valid && resp_ready[h]) begin
                    if (exp_q[h].size() == 0) begin
                        chk("resp_unexpected", 1, 0);
                    end else begin
                        e = exp_q[h].pop_front();
                        chk("resp_rs_id", resp_rs_id, e.rs);
                        chk("resp_reg_addr", resp_reg_addr, e.rg);
                        chk("resp_data", resp_data, e.d);
                    end
                    void'(m_ids.pop_front());
                end
            end else begin
                chk("idle_resp_valid", resp_valid, 0);
                chk("idle_mem_resp_ready", mem_resp_ready, 0);
            end
            if (ev && mem_req_ready) begin
                m_ids.push_back(g);
                m_last = g;
                m_lock = 1'b0;
            end else if (ev) begin
                m_lock    = 1'b1;
                m_lock_id = g;
            end
        end
    end

    // Memory and requester side effects of this cycle's handshakes.
    always @(negedge clk) begin : capture
        if (!rst) begin
            mem_pend.delete();
            acc_last = '0;
        end else begin
            if (mem_resp_valid && mem_resp_ready && mem_pend.size() > 0) void'(mem_pend.pop_front());
            if (mem_req_valid && mem_req_ready)
                mem_pend.push_back('{rs: mem_rs_id, rg: mem_reg_addr, d: memf(mem_address)});
            for (int i = 0; i < 2; i++) begin
                acc_last[i] = req_ready[i];
                if (req_ready[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
            end
        end
    end

    task automatic gen(input int i, input logic [31:0] a);
        tx_t t;
        t.rs = 5'($urandom);
        t.rg = 5'($urandom);
        t.a  = a;
        t.we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        t.wd = $urandom;
        t.re = 4'($urandom);
        req_q[i].push_back(t);
        exp_q[i].push_back('{rs: t.rs, rg: t.rg, d: memf(a)});
    endtask

    task automatic drive();
        logic v;
        for (int i = 0; i < 2; i++) begin
            v = rst && (req_q[i].size() > 0) &&
                ((req_valid[i] && !acc_last[i]) ||
                 (req_en[i] && (!req_rnd || $urandom_range(0, 1) == 1)));
            req_valid[i] = v;
            if (req_q[i].size() > 0) begin
                req_rs_id[i]      = req_q[i][0].rs;
                req_reg_addr[i]   = req_q[i][0].rg;
                req_address[i]    = req_q[i][0].a;
                req_write_en[i]   = req_q[i][0].we;
                req_write_data[i] = req_q[i][0].wd;
                req_read_en[i]    = req_q[i][0].re;
            end
            resp_ready[i] = rr_rnd ? 1'($urandom_range(0, 1)) : rr[i];
        end
        mem_req_ready  = mrdy_rnd ? 1'($urandom_range(0, 1)) : mrdy;
        mem_resp_valid = (mem_pend.size() > 0) && (resp_rnd ? ($urandom_range(0, 3) != 0) : resp_on);
        if (mem_pend.size() > 0) begin
            mem_resp_rs_id    = mem_pend[0].rs;
            mem_resp_reg_addr = mem_pend[0].rg;
            mem_read_data     = mem_pend[0].d;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
    endtask

    task automatic set_modes(input logic [1:0] en, input logic m, input logic ro, input logic [1:0] r);
        req_en = en; mrdy = m; resp_on = ro; rr = r;
        req_rnd = 1'b0; mrdy_rnd = 1'b0; resp_rnd = 1'b0; rr_rnd = 1'b0;
    endtask

    // Reset with deliberately busy inputs so the output gating is exercised too.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_q[i].delete();
            exp_q[i].delete();
        end
        req_valid = 2'b11; mem_resp_valid = 1'b1; resp_ready = 2'b11; mem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b00; mem_resp_valid = 1'b0; resp_ready = 2'b00; mem_req_ready = 1'b0;
        rst = 1'b1;
    endtask

    task automatic drain();
        int k;
        set_modes(2'b11, 1'b1, 1'b1, 2'b11);
        k = 0;
        while (k < 400 && (req_q[0].size() + req_q[1].size() + exp_q[0].size() +
                           exp_q[1].size() + mem_pend.size()) != 0) begin
            step();
            k++;
        end
        n_checks++;
        if (k >= 400) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q[0].size() + exp_q[1].size());
        end
    endtask

    initial begin : stim
        logic g, prev_g;
        logic [31:0] a0;
        do_reset();

        // 1: single LSU load, zero-latency issue, response routed back.
        set_modes(2'b01, 1'b1, 1'b0, 2'b11);
        gen(0, 32'h0000_0100);
        step();
        chk("t1_mem_address", mem_address, 32'h0000_0100);
        chk("t1_req_ready", req_ready, 2'b01);
        resp_on = 1'b1;
        step();
        chk("t1_resp_valid", resp_valid, 2'b01);
        chk("t1_resp_data", resp_data, 32'hDEAD_BEEF);
        drain();

        // 2: both requesters always valid, grants alternate starting at LSU.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            gen(0, $urandom);
            gen(1, $urandom);
        end
        set_modes(2'b11, 1'b1, 1'b1, 2'b11);
        prev_g = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_one_grant", $countones(req_ready), 1);
            g = req_ready[1];
            if (k == 0) chk("t2_first_grant", g, 0);
            else chk("t2_alternate", g, !prev_g);
            prev_g = g;
        end
        drain();

        // 3: stall holds the LSU grant while fetch waits.
        set_modes(2'b01, 1'b0, 1'b0, 2'b11);
        gen(0, $urandom);
        a0 = req_q[0][0].a;
        gen(1, $urandom);
        step();
        chk("t3_stall_ready", req_ready, 2'b00);
        chk("t3_stall_addr", mem_address, a0);
        req_en = 2'b11;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t3_locked_ready", req_ready, 2'b00);
            chk("t3_locked_addr", mem_address, a0);
        end
        mrdy = 1'b1;
        step();
        chk("t3_release", req_ready, 2'b01);
        step();
        chk("t3_fetch_next", req_ready, 2'b10);
        drain();

        // 4: outstanding limit blocks issue; a pop frees the slot only for the next cycle.
        set_modes(2'b01, 1'b1, 1'b0, 2'b01);
        for (int i = 0; i < 5; i++) gen(0, $urandom);
        repeat (4) step();
        step();
        chk("t4_full_blocks", mem_req_valid, 0);
        resp_on = 1'b1;
        step();
        chk("t4_pop", mem_resp_ready, 1);
        chk("t4_no_bypass", mem_req_valid, 0);
        resp_on = 1'b0;
        step();
        chk("t4_issue_after_pop", req_ready, 2'b01);
        drain();

        // 5: fetch holds off its response; FIFO must not pop until it is ready.
        set_modes(2'b10, 1'b1, 1'b0, 2'b00);
        gen(1, $urandom);
        step();
        resp_on = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t5_resp_valid", resp_valid, 2'b10);
            chk("t5_held", mem_resp_ready, 0);
        end
        rr = 2'b10;
        step();
        chk("t5_pop", mem_resp_ready, 1);
        step();
        chk("t5_after_pop", resp_valid, 2'b00);
        drain();

        // 6: reset with two requests in flight, then the first tie goes to LSU.
        set_modes(2'b01, 1'b1, 1'b0, 2'b00);
        gen(0, $urandom);
        gen(0, $urandom);
        gen(1, $urandom);
        repeat (2) step();
        do_reset();
        gen(0, $urandom);
        gen(1, $urandom);
        set_modes(2'b11, 1'b1, 1'b0, 2'b11);
        step();
        chk("t6_tie_after_reset", req_ready, 2'b01);
        drain();

        // Randomized traffic, handshakes and back-pressure on every interface.
        set_modes(2'b11, 1'b0, 1'b0, 2'b00);
        req_rnd = 1'b1; mrdy_rnd = 1'b1; resp_rnd = 1'b1; rr_rnd = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 2) == 0 && req_q[i].size() < 3) gen(i, $urandom);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
